div_unit: RTL
=============

# div_unit

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage and receives operands, destination register and write enable from the ID/EX pipeline register. It returns the result, the destination register and a write enable to the writeback path, and drives a busy flag to pipeline control so upstream stages hold while a division runs.

## Interface
- No parameters. Data width is fixed at 32.
- Reset is asynchronous and active-low. The block has one clock.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin a division; sampled only in IDLE.
- op_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  32  dividend (rs1).
- op2_i  in  32  divisor (rs2).
- rd_addr_i  in  5  destination register.
- flush_i  in  1  abort the division (branch/jump taken).
- busy_o  out  1  division in progress. Pipeline control stalls on this.
- ready_o  out  1  one-cycle pulse: result_o valid.
- result_o  out  32  quotient or remainder. Zero when ready_o is low.
- rd_addr_o  out  5  latched destination. Zero when ready_o is low.
- reg_wen_o  out  1  equal to ready_o.

## Operation
- States:
  - IDLE: start_i and not flush_i latches operands, op and rd, then goes to CALC. busy_o is set.
  - CALC: runs one restoring shift-subtract step per cycle. A 5-bit counter counts 0..31. After step 31 it goes to END.
  - END: applies sign fixup, registers the result, pulses ready_o, and returns to IDLE.
- Signed ops (DIV/REM):
  - Divide the absolute values.
  - Negate the quotient when the operand signs differ.
  - The remainder takes the sign of the dividend.
- Unsigned ops (DIVU/REMU) use the operands unchanged.
- Special cases (RISC-V defined, no trap):
  - Divisor 0: quotient 0xFFFFFFFF; remainder = dividend.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- start_i while busy is ignored. Control never issues it.
- flush_i in any state returns to IDLE on the next edge.
  - No ready_o pulse follows.
  - flush_i wins over a simultaneous start_i.
- If flush_i arrives in the same cycle END registers its result, the ready_o pulse is suppressed.
- Reset mid-operation: state IDLE; counter and all outputs 0.

## Timing
- Reset values: busy_o 0, ready_o 0, result_o 0, rd_addr_o 0, reg_wen_o 0.
- Edge E0 samples start_i. busy_o is high from E0 until the edge that asserts ready_o.
- Normal latency:
  - CALC occupies edges E1..E32.
  - END registers the result at E33.
  - ready_o is high for exactly the cycle after E33; busy_o is low in that same cycle.
- Special-case latency with the early-out enabled: the result registers at E1, so ready_o is high in the cycle after E1.
- A new start_i is accepted in the ready_o cycle, giving back-to-back operation.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - IDLE detects divisor 0 and the signed overflow case.
  - It jumps straight to END with the special-case result: 1-cycle latency.
- Undefined:
  - Special cases take the full 33-cycle path.
  - The result values are identical.
  - Pipeline control must not depend on latency.

## Structure
- Shared defines file holds:
  - funct3 constants INST_DIV, INST_DIVU, INST_REM, INST_REMU.
  - State encodings DIV_IDLE, DIV_CALC, DIV_END.
  - The all-ones/zero result constants.
- One combinational sub-module, div_step, performs a single shift-subtract iteration.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next partial remainder and next quotient.
- All state, the counter and the output registers live in div_unit.

## Test plan
- DIVU 100/7, start at E0:
  - busy_o high E0..E33.
  - ready_o in the cycle after E33 with result_o=14, reg_wen_o=1, rd_addr_o=the latched rd.
- REM -7 (0xFFFFFFF9) by 2: result_o=0xFFFFFFFF (-1). DIV of the same operands: result_o=0xFFFFFFFD (-3).
- DIV 5/0: 0xFFFFFFFF. REMU 5/0: 5.
  - With DIV_EARLY_OUT_EN: ready_o in the cycle after E1.
  - Without it: ready_o in the cycle after E33.
- DIV 0x80000000/0xFFFFFFFF: 0x80000000. REM of the same operands: 0.
- flush_i asserted at E10 of a DIVU:
  - IDLE at E11, no ready_o pulse.
  - Next start of 9/3 gives 3.
- rst_n dropped at E15:
  - Outputs zero immediately.
  - After release, start REMU 17/5 gives 2.

Source files
------------

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the RV32M iterative divider: funct3 encodings,
//   FSM state type, fixed result constants and small decode helpers.
//   No ports.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 encodings of the RV32M divide/remainder instructions
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_END  = 2'd2
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_ALL_ONES = '1;
    localparam logic [XLEN-1:0] DIV_ZERO     = '0;
    localparam logic [XLEN-1:0] DIV_INT_MIN  = 32'h8000_0000;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
//   Request/response bundle between the EX stage and the divider.
//   master : pipeline side (drives start/op/operands/rd/flush)
//   slave  : divider side (drives busy/ready/result/rd/wen)
//   Signals:
//     start_i, op_i[2:0], op1_i[31:0], op2_i[31:0], rd_addr_i[4:0], flush_i
//     busy_o, ready_o, result_o[31:0], rd_addr_o[4:0], reg_wen_o
// -----------------------------------------------------------------------------
interface div_unit_if;

    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;

    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wen_o;

    modport master (
        output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
        input  busy_o, ready_o, result_o, rd_addr_o, reg_wen_o
    );

    modport slave (
        input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
        output busy_o, ready_o, result_o, rd_addr_o, reg_wen_o
    );

endinterface

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring shift-subtract iteration (purely combinational).
//   Ports:
//     rem_i  partial remainder in      quo_i  quotient / dividend shift reg in
//     dvs_i  divisor (magnitude)
//     rem_o  next partial remainder    quo_o  next quotient
// -----------------------------------------------------------------------------
module div_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [31:0] sub;
    logic        fits;

    always_comb begin
        // dividend bits enter the remainder from the top of the quotient register
        shifted = {rem_i, quo_i[31]};
        fits    = (shifted >= {1'b0, dvs_i});
        // when it fits the true difference is < 2^32, so the low 32 bits suffice
        sub     = shifted[31:0] - dvs_i;
        if (fits) begin
            rem_o = sub;
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU (32 restoring steps).
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    div_unit_if.slave (start/op/operands/rd/flush in;
//            busy/ready/result/rd/wen out)
//   Build option:
//     DIV_EARLY_OUT_EN  divisor-zero and signed-overflow cases skip the
//                       iterations and finish one cycle after start.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    div_unit_if.slave  bus
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q, quo_q, dvs_q, dvd_q;
    logic [4:0]  rd_q;
    logic        is_rem_q, neg_quo_q, neg_rem_q, div0_q, ovf_q;

    logic [31:0] result_q;
    logic [4:0]  rd_out_q;
    logic        ready_q;

    logic        accept;
    logic        in_signed, in_div0, in_ovf;
    logic [31:0] in_dvd_abs, in_dvs_abs;
    logic [31:0] step_rem, step_quo;
    logic [31:0] final_res;
    logic        done;

    // ---------------- request decode ----------------
    always_comb begin
        accept     = (state_q == DIV_IDLE) && bus.start_i && !bus.flush_i;
        in_signed  = op_is_signed(bus.op_i);
        in_div0    = (bus.op2_i == DIV_ZERO);
        in_ovf     = in_signed && (bus.op1_i == DIV_INT_MIN) && (bus.op2_i == DIV_ALL_ONES);
        in_dvd_abs = (in_signed && bus.op1_i[31]) ? (DIV_ZERO - bus.op1_i) : bus.op1_i;
        in_dvs_abs = (in_signed && bus.op2_i[31]) ? (DIV_ZERO - bus.op2_i) : bus.op2_i;
    end

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DIV_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = DIV_IDLE;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (bus.start_i) begin
`ifdef DIV_EARLY_OUT_EN
                        state_d = (in_div0 || in_ovf) ? DIV_END : DIV_CALC;
`else
                        state_d = DIV_CALC;
`endif
                    end
                end
                DIV_CALC: if (cnt_q == 5'd31) state_d = DIV_END;
                DIV_END:  state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    // ---------------- result selection ----------------
    // Special cases are overridden from latched flags so the result does not
    // depend on whether the iterations actually ran.
    always_comb begin
        final_res = DIV_ZERO;
        if (div0_q) begin
            final_res = is_rem_q ? dvd_q : DIV_ALL_ONES;
        end else if (ovf_q) begin
            final_res = is_rem_q ? DIV_ZERO : DIV_INT_MIN;
        end else if (is_rem_q) begin
            final_res = neg_rem_q ? (DIV_ZERO - rem_q) : rem_q;
        end else begin
            final_res = neg_quo_q ? (DIV_ZERO - quo_q) : quo_q;
        end
        done = (state_q == DIV_END) && !bus.flush_i;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            rd_q      <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= in_dvd_abs;
            dvs_q     <= in_dvs_abs;
            dvd_q     <= bus.op1_i;
            rd_q      <= bus.rd_addr_i;
            is_rem_q  <= op_is_rem(bus.op_i);
            neg_quo_q <= in_signed && (bus.op1_i[31] ^ bus.op2_i[31]);
            neg_rem_q <= in_signed && bus.op1_i[31];
            div0_q    <= in_div0;
            ovf_q     <= in_ovf;
        end else if (state_q == DIV_CALC) begin
            cnt_q <= cnt_q + 5'd1;
            rem_q <= step_rem;
            quo_q <= step_quo;
        end
    end

    // ---------------- outputs (zero outside the ready pulse) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            ready_q  <= done;
            result_q <= done ? final_res : DIV_ZERO;
            rd_out_q <= done ? rd_q : 5'd0;
        end
    end

    assign bus.busy_o    = (state_q != DIV_IDLE);
    assign bus.ready_o   = ready_q;
    assign bus.result_o  = result_q;
    assign bus.rd_addr_o = rd_out_q;
    assign bus.reg_wen_o = ready_q;

endmodule
